// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: pipeline port, DMA port and memory side.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Pipeline (MEM stage) port
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_stall;
  logic [DATA_W-1:0] p_rdata;
  logic              p_rvalid;
  // DMA / loader port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  // Memory side
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_stall, p_rdata, p_rvalid,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rdata, d_rvalid,
    output mem_we, mem_re, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_stall, p_rdata, p_rvalid,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rdata, d_rvalid,
    input  mem_we, mem_re, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a DMA/loader port.
// Default: fixed pipeline priority with a starvation guard (NORM/FORCE_D).
// Define DMEM_ARB_RR_EN to replace the guard with round-robin on contention.
// Memory read latency is one cycle; read data is steered by a registered tag.
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  logic              gnt_p;
  logic              gnt_d;
  logic              rd_vld;
  logic              rd_own_d;
  logic [DATA_W-1:0] p_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

`ifdef DMEM_ARB_RR_EN
  // 1 when the DMA port wins the next contested cycle
  logic rr_d_next;

  // Round-robin grant: contested cycles alternate, uncontested ones pass through
  always_comb begin
    gnt_p = 1'b0;
    gnt_d = 1'b0;
    if (bus.p_req && bus.d_req) begin
      gnt_d = rr_d_next;
      gnt_p = ~rr_d_next;
    end else begin
      gnt_p = bus.p_req;
      gnt_d = bus.d_req;
    end
  end

  // Flip priority only on contested cycles; pipeline wins first after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_d_next <= 1'b0;
    end else if (bus.p_req && bus.d_req) begin
      rr_d_next <= ~rr_d_next;
    end
  end
`else
  typedef enum logic {NORM, FORCE_D} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;

  // Fixed pipeline priority; force one DMA slot once it has lost SMAX times in a row
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    gnt_p      = 1'b0;
    gnt_d      = 1'b0;
    case (state)
      NORM: begin
        if (bus.p_req) begin
          gnt_p = 1'b1;
          if (bus.d_req) begin
            if (starve_cnt >= SMAX) starve_nxt = SMAX;
            else                    starve_nxt = starve_cnt + 4'd1;
            if (starve_nxt == SMAX) state_nxt = FORCE_D;
          end else begin
            starve_nxt = '0;
          end
        end else begin
          gnt_d      = bus.d_req;
          starve_nxt = '0;
        end
      end
      FORCE_D: begin
        // The forced slot goes unused by DMA if it dropped its request;
        // the pipeline may take it instead.
        gnt_d      = bus.d_req;
        gnt_p      = bus.p_req & ~bus.d_req;
        starve_nxt = '0;
        state_nxt  = NORM;
      end
      default: begin
        state_nxt  = NORM;
        starve_nxt = '0;
      end
    endcase
  end

  // State and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORM;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end
`endif

  // Memory side mirrors the granted port; all zero when nobody is granted
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_p) begin
      bus.mem_we    = bus.p_we;
      bus.mem_re    = ~bus.p_we;
      bus.mem_addr  = bus.p_addr;
      bus.mem_wdata = bus.p_wdata;
    end else if (gnt_d) begin
      bus.mem_we    = bus.d_we;
      bus.mem_re    = ~bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  // Read-owner tag for the access whose data returns next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      rd_own_d <= 1'b0;
    end else begin
      rd_vld   <= bus.mem_re;
      rd_own_d <= gnt_d;
    end
  end

  // Hold the last returned word per port for the cycles without rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (rd_vld) begin
      if (rd_own_d) d_rdata_q <= bus.mem_rdata;
      else          p_rdata_q <= bus.mem_rdata;
    end
  end

  // Port-side outputs: stall, grant and steered read data
  always_comb begin
    bus.p_stall  = bus.p_req & ~gnt_p;
    bus.d_gnt    = gnt_d;
    bus.p_rvalid = rd_vld & ~rd_own_d;
    bus.d_rvalid = rd_vld & rd_own_d;
    bus.p_rdata  = bus.p_rvalid ? bus.mem_rdata : p_rdata_q;
    bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : d_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle grant/memory
// expectations and read-data expectations; a negedge monitor pops and compares.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        p_stall;
    logic        d_gnt;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
  } cyc_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cyc_t        cyc_q[$];
  logic [15:0] prd_q[$];
  logic [15:0] drd_q[$];
  logic [15:0] mem [256];

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model; contents are A000|addr after each reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end

  function automatic cyc_t mk(input logic s, input logic g, input logic we,
                              input logic re, input logic [15:0] a,
                              input logic [15:0] d);
    mk = {s, g, we, re, a, d};
  endfunction

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step(input logic pr, input logic pw, input logic [15:0] pa,
                      input logic [15:0] pd, input logic dr, input logic dw,
                      input logic [15:0] da, input logic [15:0] dd, input cyc_t e);
    bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, '0);
  endtask

  // Monitor: compare every expected cycle and every returned read word
  always @(negedge clk) begin
    cyc_t a;
    cyc_t e;
    logic [15:0] w;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      a = {bus.p_stall, bus.d_gnt, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_grant_mem: got %h want %h", a, e);
      end
    end
    if (bus.p_rvalid !== 1'b0) begin
      n_checks++;
      if (prd_q.size() == 0) begin
        n_fail++;
        $display("FAIL p_rvalid_unexpected: got %b want 0", bus.p_rvalid);
      end else begin
        w = prd_q.pop_front();
        if (bus.p_rdata !== w) begin
          n_fail++;
          $display("FAIL p_rdata: got %h want %h", bus.p_rdata, w);
        end
      end
    end
    if (bus.d_rvalid !== 1'b0) begin
      n_checks++;
      if (drd_q.size() == 0) begin
        n_fail++;
        $display("FAIL d_rvalid_unexpected: got %b want 0", bus.d_rvalid);
      end else begin
        w = drd_q.pop_front();
        if (bus.d_rdata !== w) begin
          n_fail++;
          $display("FAIL d_rdata: got %h want %h", bus.d_rdata, w);
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_p_rvalid", 36'(bus.p_rvalid), 36'h0);
    chk("rst_d_rvalid", 36'(bus.d_rvalid), 36'h0);
    chk("rst_p_rdata", 36'(bus.p_rdata), 36'h0);
    chk("rst_d_rdata", 36'(bus.d_rdata), 36'h0);
`ifndef DMEM_ARB_RR_EN
    chk("rst_state", 36'(dut.state), 36'h0);
    chk("rst_starve", 36'(dut.starve_cnt), 36'h0);
`endif

    // Pipeline write then read back, no stall
    step(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, mk(0, 0, 1, 0, 16'h0010, 16'hBEEF));
    prd_q.push_back(16'hBEEF);
    step(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, 16'h0, mk(0, 0, 0, 1, 16'h0010, 16'h0000));
    idle();

    // Alternating owners, back-to-back reads, no cross-routing
    prd_q.push_back(16'hA020);
    step(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, mk(0, 0, 0, 1, 16'h0020, 16'h0));
    drd_q.push_back(16'hA030);
    step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0030, 16'h0, mk(0, 1, 0, 1, 16'h0030, 16'h0));
    idle();
    chk("p_rdata_hold", 36'(bus.p_rdata), 36'hA020);
    chk("d_rdata_hold", 36'(bus.d_rdata), 36'hA030);

`ifdef DMEM_ARB_RR_EN
    // Continuous contention alternates P, D, P, D ...
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 16'h0040, 16'h1111, 1, 1, 16'h0050, 16'h2222,
           (i % 2 == 0) ? mk(0, 0, 1, 0, 16'h0040, 16'h1111)
                        : mk(1, 1, 1, 0, 16'h0050, 16'h2222));
    end
    idle();
`else
    // Continuous contention: DMA forced in on the 5th and 10th cycles
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 16'h0040, 16'h1111, 1, 1, 16'h0050, 16'h2222,
           (i == 5 || i == 10) ? mk(1, 1, 1, 0, 16'h0050, 16'h2222)
                               : mk(0, 0, 1, 0, 16'h0040, 16'h1111));
    end
    chk("starve_after_force", 36'(dut.starve_cnt), 36'h0);
    idle();

    // Two contested cycles, then reset while a DMA read is issued
    step(1, 1, 16'h0041, 16'h3333, 1, 0, 16'h0031, 16'h0, mk(0, 0, 1, 0, 16'h0041, 16'h3333));
    step(1, 1, 16'h0041, 16'h3333, 1, 0, 16'h0031, 16'h0, mk(0, 0, 1, 0, 16'h0041, 16'h3333));
    chk("starve_count_2", 36'(dut.starve_cnt), 36'h2);
`endif

    rst = 1'b1;
    step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0030, 16'h0, mk(0, 1, 0, 1, 16'h0030, 16'h0));
    rst = 1'b0;
    chk("rst_rd_d_rvalid", 36'(bus.d_rvalid), 36'h0);
    chk("rst_rd_d_rdata", 36'(bus.d_rdata), 36'h0);
`ifndef DMEM_ARB_RR_EN
    chk("rst_rd_state", 36'(dut.state), 36'h0);
    chk("rst_rd_starve", 36'(dut.starve_cnt), 36'h0);
`endif
    idle();

    // DMA alone: granted every cycle, pipeline never stalled
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0060 + 16'(i), 16'(i),
           mk(0, 1, 1, 0, 16'h0060 + 16'(i), 16'(i)));
    end
`ifndef DMEM_ARB_RR_EN
    chk("dma_only_starve", 36'(dut.starve_cnt), 36'h0);
`endif
    idle();
    idle();

    // Every expectation must have been consumed
    chk("cyc_q_empty", 36'(cyc_q.size()), 36'h0);
    chk("prd_q_empty", 36'(prd_q.size()), 36'h0);
    chk("drd_q_empty", 36'(drd_q.size()), 36'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the memory data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, range 1..15, meaning the maximum number of consecutive cycles the DMA port may lose arbitration.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have pipeline-port inputs p_req, p_we (1 bit each), p_addr (ADDR_W) and p_wdata (DATA_W): the MEM-stage access request.
REQ-007 The block SHALL have pipeline-port outputs p_stall (1 bit), p_rdata (DATA_W) and p_rvalid (1 bit).
REQ-008 The block SHALL have DMA-port inputs d_req, d_we (1 bit each), d_addr (ADDR_W) and d_wdata (DATA_W): the DMA/loader access request.
REQ-009 The block SHALL have DMA-port outputs d_gnt (1 bit), d_rdata (DATA_W) and d_rvalid (1 bit).
REQ-010 The block SHALL have memory-side outputs mem_we, mem_re (1 bit each), mem_addr (ADDR_W) and mem_wdata (DATA_W), plus input mem_rdata (DATA_W).
REQ-011 The memory SHALL have synchronous read: mem_rdata is valid in the cycle after mem_re.

Function
REQ-012 The block SHALL issue at most one memory access per cycle to exactly one owner.
REQ-013 The block SHALL use FSM states NORM and FORCE_D.
REQ-014 In NORM, with both requests active, the block SHALL grant the pipeline and increment starve_cnt.
REQ-015 In NORM, a DMA grant or an idle d_req SHALL clear starve_cnt.
REQ-016 In NORM, when starve_cnt reaches STARVE_MAX with d_req still high, the next state SHALL be FORCE_D.
REQ-017 In FORCE_D, the block SHALL grant DMA if d_req is high, clear starve_cnt, and return to NORM next cycle whether or not d_req was high.
REQ-018 The grant SHALL be combinational from the current state and requests; d_gnt=1 means the DMA access is issued this cycle.
REQ-019 p_stall SHALL equal p_req AND NOT pipeline-granted, combinationally.
REQ-020 The pipeline SHALL hold its request stable while stalled; a held-but-changed request SHALL be arbitrated as new with no error.
REQ-021 The mem_* outputs SHALL mirror the granted port's signals: mem_re = granted AND NOT we; mem_we = granted AND we.
REQ-022 With no grant, mem_re, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-023 The block SHALL register a read-owner tag when issuing a read.
REQ-024 Next cycle, the block SHALL route mem_rdata to the tagged owner's rdata and pulse that owner's rvalid for 1 cycle.
REQ-025 The other port's rdata SHALL hold its last value and its rvalid SHALL be 0.
REQ-026 Writes SHALL produce no rvalid.
REQ-027 Back-to-back reads by alternating owners SHALL each return correctly with 1-cycle latency.
REQ-028 starve_cnt SHALL saturate at STARVE_MAX and never wrap.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL go to state NORM with starve_cnt=0, read-owner tag cleared, p_rvalid=0, d_rvalid=0, p_rdata=0 and d_rdata=0.
REQ-030 A read issued in the cycle when rst is asserted SHALL produce no rvalid.
REQ-031 The grant and mem_* outputs SHALL stay combinational during reset; the requester is responsible for quiescing them.

Configuration
REQ-032 With macro DMEM_ARB_RR_EN defined, NORM SHALL alternate grants when both ports request: the port not granted last contested cycle wins, the pipeline winning the first contest after reset.
REQ-033 With DMEM_ARB_RR_EN defined, the starvation counter and FORCE_D SHALL be absent.
REQ-034 Without DMEM_ARB_RR_EN, the block SHALL use fixed pipeline priority plus the starvation guard of REQ-014 to REQ-017.

Verification
REQ-035 Bench scenario: p_req write addr 0x0010 data 0xBEEF, then p_req read 0x0010 -> mem_we=1 cycle 0, p_rdata=0xBEEF with p_rvalid=1 at cycle 2, p_stall=0 throughout.
REQ-036 Bench scenario: p_req and d_req held high, STARVE_MAX=4, fixed priority -> pipeline granted 4 cycles, 5th cycle d_gnt=1 and p_stall=1, then pipeline again.
REQ-037 Bench scenario: with DMEM_ARB_RR_EN and both ports requesting continuously -> grants P,D,P,D...; each stalled cycle shows p_stall=1.
REQ-038 Bench scenario: pipeline read 0x0020 at cycle n, DMA read 0x0030 at cycle n+1 -> p_rvalid at n+1 with mem[0x20], d_rvalid at n+2 with mem[0x30], no cross-routing.
REQ-039 Bench scenario: rst asserted the cycle a DMA read is issued -> d_rvalid stays 0, FSM=NORM, starve_cnt=0.
REQ-040 Bench scenario: only d_req for 10 cycles -> d_gnt=1 every cycle, starve_cnt stays 0, p_stall=0.
